aes_sub_stage: RTL

//  Sequential successor to the combinational SubBytes/SubWord stage of the AES round datapath.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sbox.sv | 12 +
 rtl/aes_sub_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: FIPS-197 forward/inverse S-box tables, byte counts,
// the sub-stage FSM encoding and a single-byte substitution helper.
package aes_pkg;

  localparam int AES_BYTES  = 16;
  localparam int SUBW_BYTES = 4;
  localparam int WORK_BYTES = AES_BYTES + SUBW_BYTES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } sub_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational S-box lane; inv selects the inverse table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  assign dout = sub_byte(din, inv);

endmodule

// File: rtl/aes_sub_stage.sv
// Multi-cycle SubBytes/SubWord stage: LANES shared S-boxes walk a 20-byte work
// list (16 state bytes, then key bytes 12..15) with valid/ready on both sides.
module aes_sub_stage
  import aes_pkg::*;
#(
  parameter int LANES = 20,
  parameter int TAG_W = 1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             inv_mode,
  input  logic [127:0]     state_in,
  input  logic [127:0]     key_in,
  input  logic [7:0]       rcon_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     state_out,
  output logic [127:0]     key_out,
  output logic [7:0]       rcon_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int N      = WORK_BYTES / LANES;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 5 || LANES == 10 || LANES == 20))
  begin : g_bad_lanes
    $error("aes_sub_stage: LANES must be one of 1, 2, 4, 5, 10, 20");
  end

  sub_state_e        r_fsm, w_fsm_next;
  logic [BEAT_W-1:0] r_beat;
  logic              r_inv;
  logic [127:0]      r_state_in, r_key_in;
  logic [7:0]        r_rcon;
  logic [TAG_W-1:0]  r_tag;
  logic [7:0]        r_res [WORK_BYTES];

  logic [7:0]            w_work [WORK_BYTES];
  logic [4:0]            w_sel  [LANES];
  logic [7:0]            w_din  [LANES];
  logic [7:0]            w_dout [LANES];
  logic                  w_inv  [LANES];
  logic [WORK_BYTES-1:0] w_we;
  logic                  w_accept, w_last;

  for (genvar i = 0; i < AES_BYTES; i++) begin : g_work_state
    assign w_work[i] = r_state_in[127-8*i -: 8];
  end
  for (genvar j = 0; j < SUBW_BYTES; j++) begin : g_work_key
    assign w_work[AES_BYTES+j] = r_key_in[31-8*j -: 8];
  end

  // Key-word lanes always take the forward table, whatever mode was captured.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sel[l] = 5'(int'(r_beat) * LANES + l);
      w_din[l] = w_work[w_sel[l]];
      w_inv[l] = r_inv && (w_sel[l] < 5'(AES_BYTES));
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox u_sbox (
      .din  (w_din[l]),
      .inv  (w_inv[l]),
      .dout (w_dout[l])
    );
  end

  always_comb begin
    for (int i = 0; i < WORK_BYTES; i++) begin
      w_we[i] = (r_fsm == S_SUB) && (r_beat == BEAT_W'(i / LANES));
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = S_SUB;
      end
      S_SUB: begin
        if (w_last) w_fsm_next = S_DONE;
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) w_fsm_next = in_valid ? S_SUB : S_IDLE;
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_beat == BEAT_W'(N - 1));
  assign out_valid = (r_fsm == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat     <= '0;
      r_inv      <= 1'b0;
      r_state_in <= '0;
      r_key_in   <= '0;
      r_rcon     <= '0;
      r_tag      <= '0;
      for (int i = 0; i < WORK_BYTES; i++) r_res[i] <= 8'h00;
    end else begin
      if (w_accept) begin
        r_beat     <= '0;
        r_inv      <= inv_mode;
        r_state_in <= state_in;
        r_key_in   <= key_in;
        r_rcon     <= rcon_in;
        r_tag      <= tag_in;
      end else if (r_fsm == S_SUB) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
      for (int i = 0; i < WORK_BYTES; i++) begin
        if (w_we[i]) r_res[i] <= w_dout[i % LANES];
      end
    end
  end

  for (genvar i = 0; i < AES_BYTES; i++) begin : g_out_state
    assign state_out[127-8*i -: 8] = r_res[i];
  end
  assign key_out[127:32] = r_key_in[127:32];
  for (genvar j = 0; j < SUBW_BYTES; j++) begin : g_out_key
    assign key_out[31-8*j -: 8] = r_res[AES_BYTES+j];
  end
  assign rcon_out = r_rcon;
  assign tag_out  = r_tag;

endmodule
